// File: rtl/imem_server.sv
// Instruction memory server: word array with preload port, fixed-latency read pipeline and a 2-deep response FIFO.
// Optional alignment fault checking is enabled by defining IMEM_SERVER_ALIGN_CHK_EN.
module imem_server #(
  parameter int          DEPTH_LOG2 = 10,
  parameter logic [31:0] BASE       = 32'h8000_0000,
  parameter int          LAT        = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [31:0]           req_addr,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_inst,
  output logic                  rsp_err,
  input  logic                  ld_en,
  input  logic [DEPTH_LOG2-1:0] ld_addr,
  input  logic [31:0]           ld_data
);

  localparam int          DEPTH = 1 << DEPTH_LOG2;
  localparam logic [32:0] SPAN  = 33'd4 << DEPTH_LOG2;

  logic [31:0]           mem [DEPTH];

  logic [1:0]            c_q, c_d;
  logic [LAT-1:0]        pv_q, pv_d;
  logic [LAT-1:0]        pe_q, pe_d;
  logic [31:0]           pd_q [LAT];
  logic [31:0]           pd_d [LAT];
  logic [31:0]           fd_q [2];
  logic [31:0]           fd_d [2];
  logic [1:0]            fe_q, fe_d;
  logic [1:0]            fc_q, fc_d;

  logic                  accept_s;
  logic                  pop_s;
  logic                  push_s;
  logic [31:0]           off_s;
  logic [DEPTH_LOG2-1:0] idx_s;
  logic                  acc_err_s;
  logic [31:0]           acc_data_s;
  logic [1:0]            keep_s;
  logic                  wr_idx_s;

  assign req_ready = (c_q < 2'd2) && !reset;
  assign accept_s  = req_valid && req_ready;
  assign rsp_valid = (fc_q != 2'd0);
  assign pop_s     = rsp_valid && rsp_ready;
  assign push_s    = pv_q[LAT-1];
  assign rsp_inst  = rsp_valid ? fd_q[0] : 32'h0000_0000;
  assign rsp_err   = rsp_valid && fe_q[0];

  // Address decode and array read at the accepting edge (write-first is avoided: old word wins).
  always_comb begin
    off_s     = req_addr - BASE;
    idx_s     = off_s[DEPTH_LOG2+1:2];
`ifdef IMEM_SERVER_ALIGN_CHK_EN
    acc_err_s = ({1'b0, off_s} >= SPAN) || (req_addr[1:0] != 2'b00);
`else
    acc_err_s = ({1'b0, off_s} >= SPAN);
`endif
    acc_data_s = acc_err_s ? 32'h0000_0000 : mem[idx_s];
  end

  // Latency pipeline: free-running shift, overflow is prevented by the outstanding limit.
  always_comb begin
    pv_d    = pv_q;
    pe_d    = pe_q;
    pd_d    = pd_q;
    pv_d[0] = accept_s;
    pe_d[0] = acc_err_s;
    pd_d[0] = acc_data_s;
    for (int k = 1; k < LAT; k++) begin
      pv_d[k] = pv_q[k-1];
      pe_d[k] = pe_q[k-1];
      pd_d[k] = pd_q[k-1];
    end
  end

  // Response FIFO (entry 0 is the head) and outstanding counter.
  always_comb begin
    fd_d   = fd_q;
    fe_d   = fe_q;
    if (pop_s) begin
      fd_d[0] = fd_q[1];
      fe_d[0] = fe_q[1];
    end else begin
      fd_d[0] = fd_q[0];
      fe_d[0] = fe_q[0];
    end
    keep_s   = fc_q - {1'b0, pop_s};
    wr_idx_s = keep_s[0];
    if (push_s) begin
      fd_d[wr_idx_s] = pd_q[LAT-1];
      fe_d[wr_idx_s] = pe_q[LAT-1];
      fc_d           = keep_s + 2'd1;
    end else begin
      fc_d           = keep_s;
    end
    c_d = c_q + {1'b0, accept_s} - {1'b0, pop_s};
  end

  // Control state with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      c_q  <= 2'd0;
      pv_q <= {LAT{1'b0}};
      fc_q <= 2'd0;
    end else begin
      c_q  <= c_d;
      pv_q <= pv_d;
      fc_q <= fc_d;
    end
  end

  // Payload registers; qualified by the valid state so they need no reset.
  always_ff @(posedge clk) begin
    pe_q <= pe_d;
    pd_q <= pd_d;
    fe_q <= fe_d;
    fd_q <= fd_d;
  end

  // Preload port, deliberately unaffected by reset.
  always_ff @(posedge clk) begin
    if (ld_en) begin
      mem[ld_addr] <= ld_data;
    end
  end

endmodule

// File: tb/tb_imem_server.sv
// Self-checking bench for imem_server: constant-expectation vectors plus a queue-based reference model.
module tb_imem_server;

  localparam int LAT = 2;

`ifdef IMEM_SERVER_ALIGN_CHK_EN
  localparam logic [31:0] MIS_INST = 32'h0000_0000;
  localparam logic        MIS_ERR  = 1'b1;
`else
  localparam logic [31:0] MIS_INST = 32'h0010_0093;
  localparam logic        MIS_ERR  = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, req_valid, req_ready, rsp_valid, rsp_ready, rsp_err, ld_en;
  logic [31:0] req_addr, rsp_inst, ld_data;
  logic [9:0]  ld_addr;

  imem_server #(.DEPTH_LOG2(10), .BASE(32'h8000_0000), .LAT(LAT)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_inst(rsp_inst), .rsp_err(rsp_err),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, rv, rr, le;
    logic [31:0] addr, ld;
    logic [9:0]  la;
    logic        chk, e_ready, e_valid, e_err;
    logic [31:0] e_inst;
  } vec_t;

  typedef struct {
    logic [31:0] inst;
    logic        err;
    int          due;
  } rsp_t;

  logic [31:0] ref_mem [1024];
  rsp_t        pend[$];
  rsp_t        outq[$];
  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  vec_t        tbl[$];

  function automatic vec_t mk(logic rst, logic rv, logic [31:0] addr, logic rr,
                              logic le, logic [9:0] la, logic [31:0] ld,
                              logic chk, logic er, logic ev, logic [31:0] ei, logic ee);
    vec_t v;
    v.rst = rst; v.rv = rv; v.addr = addr; v.rr = rr; v.le = le; v.la = la; v.ld = ld;
    v.chk = chk; v.e_ready = er; v.e_valid = ev; v.e_inst = ei; v.e_err = ee;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Reference model step at one rising edge, using the rules of the interface contract.
  task automatic model_edge(vec_t v);
    logic        hs, acc;
    logic [31:0] off;
    rsp_t        r;
    hs  = (outq.size() > 0) && v.rr;
    acc = v.rv && ((pend.size() + outq.size()) < 2) && !v.rst;
    off = v.addr - 32'h8000_0000;
    r.err = (off >= 32'd4096);
`ifdef IMEM_SERVER_ALIGN_CHK_EN
    if (v.addr[1:0] != 2'b00) r.err = 1'b1;
`endif
    r.inst = r.err ? 32'h0 : ref_mem[off[11:2]];
    r.due  = cyc + LAT;
    if (v.rst) begin
      pend.delete();
      outq.delete();
    end else begin
      if (hs) void'(outq.pop_front());
      while (pend.size() > 0 && pend[0].due == cyc) outq.push_back(pend.pop_front());
      if (acc) pend.push_back(r);
    end
    if (v.le) ref_mem[v.la] = v.ld;
    cyc++;
  endtask

  task automatic run_vec(vec_t v, logic use_model);
    logic        m_ready, m_valid, m_err;
    logic [31:0] m_inst;
    @(negedge clk);
    reset = v.rst; req_valid = v.rv; req_addr = v.addr; rsp_ready = v.rr;
    ld_en = v.le; ld_addr = v.la; ld_data = v.ld;
    #1;
    if (v.chk) begin
      chk("vec_req_ready", {31'd0, req_ready}, {31'd0, v.e_ready});
      chk("vec_rsp_valid", {31'd0, rsp_valid}, {31'd0, v.e_valid});
      chk("vec_rsp_inst", rsp_inst, v.e_inst);
      chk("vec_rsp_err", {31'd0, rsp_err}, {31'd0, v.e_err});
    end
    if (use_model) begin
      m_ready = ((pend.size() + outq.size()) < 2) && !v.rst;
      m_valid = (outq.size() > 0);
      m_inst  = m_valid ? outq[0].inst : 32'h0;
      m_err   = m_valid ? outq[0].err : 1'b0;
      chk("mdl_req_ready", {31'd0, req_ready}, {31'd0, m_ready});
      chk("mdl_rsp_valid", {31'd0, rsp_valid}, {31'd0, m_valid});
      chk("mdl_rsp_inst", rsp_inst, m_inst);
      chk("mdl_rsp_err", {31'd0, rsp_err}, {31'd0, m_err});
    end
    @(posedge clk);
    model_edge(v);
  endtask

  initial begin
    vec_t v;
    // Unchecked start-up reset, then bulk preload during reset.
    for (int i = 0; i < 3; i++) run_vec(mk(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 10'd0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0), 1'b0);
    for (int i = 0; i < 1024; i++)
      run_vec(mk(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, i[9:0], $urandom, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0), 1'b1);

    // Known words loaded under reset, then basic fetch, out-of-range and misaligned fetches.
    tbl.push_back(mk(1, 0, 32'h0,         1, 1, 10'd0, 32'h0010_0093, 1, 0, 0, 32'h0, 0));
    tbl.push_back(mk(1, 0, 32'h0,         1, 1, 10'd1, 32'h1111_1111, 1, 0, 0, 32'h0, 0));
    tbl.push_back(mk(1, 0, 32'h0,         1, 1, 10'd2, 32'h2222_2222, 1, 0, 0, 32'h0, 0));
    tbl.push_back(mk(1, 0, 32'h0,         1, 1, 10'd3, 32'h3333_3333, 1, 0, 0, 32'h0, 0));
    tbl.push_back(mk(1, 0, 32'h0,         1, 1, 10'd5, 32'hAAAA_0005, 1, 0, 0, 32'h0, 0));
    tbl.push_back(mk(0, 1, 32'h8000_0000, 1, 0, 10'd0, 32'h0,         1, 1, 0, 32'h0, 0));
    tbl.push_back(mk(0, 0, 32'h0,         1, 0, 10'd0, 32'h0,         1, 1, 0, 32'h0, 0));
    tbl.push_back(mk(0, 0, 32'h0,         1, 0, 10'd0, 32'h0,         1, 1, 0, 32'h0, 0));
    tbl.push_back(mk(0, 0, 32'h0,         1, 0, 10'd0, 32'h0,         1, 1, 1, 32'h0010_0093, 0));
    tbl.push_back(mk(0, 0, 32'h0,         1, 0, 10'd0, 32'h0,         1, 1, 0, 32'h0, 0));
    tbl.push_back(mk(0, 1, 32'h7FFF_FFFC, 1, 0, 10'd0, 32'h0,         1, 1, 0, 32'h0, 0));
    tbl.push_back(mk(0, 1, 32'h8000_1000, 1, 0, 10'd0, 32'h0,         1, 1, 0, 32'h0, 0));
    tbl.push_back(mk(0, 0, 32'h0,         1, 0, 10'd0, 32'h0,         1, 0, 0, 32'h0, 0));
    tbl.push_back(mk(0, 0, 32'h0,         1, 0, 10'd0, 32'h0,         1, 0, 1, 32'h0, 1));
    tbl.push_back(mk(0, 0, 32'h0,         1, 0, 10'd0, 32'h0,         1, 1, 1, 32'h0, 1));
    tbl.push_back(mk(0, 0, 32'h0,         1, 0, 10'd0, 32'h0,         1, 1, 0, 32'h0, 0));
    tbl.push_back(mk(0, 1, 32'h8000_0002, 1, 0, 10'd0, 32'h0,         1, 1, 0, 32'h0, 0));
    tbl.push_back(mk(0, 0, 32'h0,         1, 0, 10'd0, 32'h0,         1, 1, 0, 32'h0, 0));
    tbl.push_back(mk(0, 0, 32'h0,         1, 0, 10'd0, 32'h0,         1, 1, 0, 32'h0, 0));
    tbl.push_back(mk(0, 0, 32'h0,         1, 0, 10'd0, 32'h0,         1, 1, 1, MIS_INST, MIS_ERR));
    tbl.push_back(mk(0, 0, 32'h0,         1, 0, 10'd0, 32'h0,         1, 1, 0, 32'h0, 0));
    for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], 1'b1);

    // Backpressure: third request waits for the first handshake; order and hold are preserved.
    run_vec(mk(0, 1, 32'h8000_0004, 0, 0, 10'd0, 32'h0, 1, 1, 0, 32'h0, 0), 1'b1);
    run_vec(mk(0, 1, 32'h8000_0008, 0, 0, 10'd0, 32'h0, 1, 1, 0, 32'h0, 0), 1'b1);
    run_vec(mk(0, 1, 32'h8000_000C, 0, 0, 10'd0, 32'h0, 1, 0, 0, 32'h0, 0), 1'b1);
    run_vec(mk(0, 1, 32'h8000_000C, 0, 0, 10'd0, 32'h0, 1, 0, 1, 32'h1111_1111, 0), 1'b1);
    run_vec(mk(0, 1, 32'h8000_000C, 1, 0, 10'd0, 32'h0, 1, 0, 1, 32'h1111_1111, 0), 1'b1);
    run_vec(mk(0, 1, 32'h8000_000C, 1, 0, 10'd0, 32'h0, 1, 1, 1, 32'h2222_2222, 0), 1'b1);
    run_vec(mk(0, 0, 32'h0,         1, 0, 10'd0, 32'h0, 1, 1, 0, 32'h0, 0), 1'b1);
    run_vec(mk(0, 0, 32'h0,         1, 0, 10'd0, 32'h0, 1, 1, 0, 32'h0, 0), 1'b1);
    run_vec(mk(0, 0, 32'h0,         1, 0, 10'd0, 32'h0, 1, 1, 1, 32'h3333_3333, 0), 1'b1);
    run_vec(mk(0, 0, 32'h0,         1, 0, 10'd0, 32'h0, 1, 1, 0, 32'h0, 0), 1'b1);

    // Same-edge preload and fetch of index 5: old word first, new word on the re-fetch.
    run_vec(mk(0, 1, 32'h8000_0014, 1, 1, 10'd5, 32'hBBBB_0005, 1, 1, 0, 32'h0, 0), 1'b1);
    run_vec(mk(0, 1, 32'h8000_0014, 1, 0, 10'd0, 32'h0, 1, 1, 0, 32'h0, 0), 1'b1);
    run_vec(mk(0, 0, 32'h0,         1, 0, 10'd0, 32'h0, 1, 0, 0, 32'h0, 0), 1'b1);
    run_vec(mk(0, 0, 32'h0,         1, 0, 10'd0, 32'h0, 1, 0, 1, 32'hAAAA_0005, 0), 1'b1);
    run_vec(mk(0, 0, 32'h0,         1, 0, 10'd0, 32'h0, 1, 1, 1, 32'hBBBB_0005, 0), 1'b1);
    run_vec(mk(0, 0, 32'h0,         1, 0, 10'd0, 32'h0, 1, 1, 0, 32'h0, 0), 1'b1);

    // Reset right after two accepts: nothing in flight may ever surface.
    run_vec(mk(0, 1, 32'h8000_0000, 1, 0, 10'd0, 32'h0, 1, 1, 0, 32'h0, 0), 1'b1);
    run_vec(mk(0, 1, 32'h8000_0004, 1, 0, 10'd0, 32'h0, 1, 1, 0, 32'h0, 0), 1'b1);
    run_vec(mk(1, 0, 32'h0,         1, 0, 10'd0, 32'h0, 1, 0, 0, 32'h0, 0), 1'b1);
    for (int i = 0; i < 5; i++)
      run_vec(mk(0, 0, 32'h0, 1, 0, 10'd0, 32'h0, 1, 1, 0, 32'h0, 0), 1'b1);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      int unsigned r;
      r = $urandom_range(0, 9);
      v = mk(($urandom_range(0, 99) == 0), $urandom_range(0, 1), 32'h0, ($urandom_range(0, 3) != 0),
             ($urandom_range(0, 3) == 0), 10'($urandom_range(0, 1023)), $urandom,
             1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      case (r)
        0:       v.addr = $urandom;
        1:       v.addr = 32'h8000_1000 + ($urandom_range(0, 15) << 2);
        2:       v.addr = 32'h7FFF_FFFC;
        3:       v.addr = 32'h8000_0000 + ($urandom_range(0, 1023) << 2) + $urandom_range(0, 3);
        default: v.addr = 32'h8000_0000 + ($urandom_range(0, 1023) << 2);
      endcase
      run_vec(v, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_server.md
IMEM_SERVER -- requirements
Module: imem_server

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 10, log2 of memory depth in 32-bit words.
REQ-002 SHALL have parameter BASE, default 32'h80000000, byte address of word 0.
REQ-003 SHALL have parameter LAT, default 2, request-to-response latency in cycles, legal range 1..7.
REQ-004 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port req_valid  input  1  fetch request present.
REQ-007 SHALL have port req_ready  output  1  request accepted when high with req_valid.
REQ-008 SHALL have port req_addr  input  32  fetch byte address (the core's pc).
REQ-009 SHALL have port rsp_valid  output  1  response present.
REQ-010 SHALL have port rsp_ready  input  1  response consumed when high with rsp_valid.
REQ-011 SHALL have port rsp_inst  output  32  instruction word.
REQ-012 SHALL have port rsp_err  output  1  access fault flag for this response.
REQ-013 SHALL have ports ld_en input 1, ld_addr input DEPTH_LOG2, ld_data input 32: preload write port.

Function
REQ-014 SHALL hold a 2^DEPTH_LOG2 x 32 array; index = (req_addr - BASE) >> 2, 32-bit unsigned subtraction with wrap.
REQ-015 SHALL treat an address as in range iff (req_addr - BASE) < 4*2^DEPTH_LOG2; addresses below BASE wrap to large values, hence out of range.
REQ-016 SHALL accept a request on an edge where req_valid && req_ready; the array is read at that edge.
REQ-017 SHALL carry each accepted request through a LAT-stage valid/data pipeline into a 2-entry in-order response FIFO.
REQ-018 SHALL, with FIFO empty and rsp_ready high, raise rsp_valid exactly LAT cycles after the accepting edge.
REQ-019 SHALL keep outstanding counter C (0..2): +1 on accept, -1 on response handshake, unchanged when both occur on one edge.
REQ-020 SHALL drive req_ready = (C < 2) && !reset; FIFO overflow is therefore impossible.
REQ-021 SHALL hold rsp_valid, rsp_inst, rsp_err stable while rsp_valid && !rsp_ready.
REQ-022 SHALL return responses in acceptance order.
REQ-023 SHALL, for an out-of-range request, return rsp_inst = 0 and rsp_err = 1; otherwise rsp_err = 0.
REQ-024 SHALL write ld_data to array[ld_addr] on an edge with ld_en high, independent of fetch traffic.
REQ-025 SHALL return the old word when ld_en writes the same index a request reads on the same edge.
REQ-026 SHALL drive rsp_inst = 0 and rsp_err = 0 whenever rsp_valid is low.

Reset
REQ-027 SHALL clear C, pipeline valids and FIFO on any edge with reset high; the outputs after that edge are rsp_valid 0, rsp_inst 0, rsp_err 0, req_ready 1.
REQ-028 SHALL discard in-flight and queued responses when reset is asserted mid-operation; none are delivered after reset.
REQ-029 SHALL NOT clear array contents on reset; ld_en writes SHALL remain effective during reset.

Configuration
REQ-030 SHALL honour macro IMEM_SERVER_ALIGN_CHK_EN: when defined, req_addr[1:0] != 0 yields rsp_inst = 0, rsp_err = 1; when undefined, req_addr[1:0] is ignored and the containing word is returned.

Verification
REQ-031 Preload word0 = 32'h00100093 via ld, reset, request 32'h80000000 with LAT=2 -> rsp_valid 2 cycles later, rsp_inst 32'h00100093, rsp_err 0.
REQ-032 rsp_ready held low, 3 back-to-back requests -> req_ready falls after the 2nd accept; 3rd accepted only after the first response handshake; order preserved.
REQ-033 Request 32'h7FFFFFFC and 32'h80001000 (DEPTH_LOG2=10) -> both rsp_err 1, rsp_inst 0.
REQ-034 Request 32'h80000002 -> err 1 with IMEM_SERVER_ALIGN_CHK_EN; word0 data, err 0 without it.
REQ-035 ld write to index 5 on the same edge as a fetch of 32'h80000014 -> old data returned; re-fetch returns new data.
REQ-036 Assert reset one cycle after two accepts -> no responses ever appear; C = 0; req_ready 1 after reset releases.
